// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the E-stage multiply/divide unit: operation codes,
// HI/LO write selects and the FSM state type.
package muldiv_unit_pkg;

    localparam logic [2:0] MD_OP_MULT  = 3'd0;
    localparam logic [2:0] MD_OP_MULTU = 3'd1;
    localparam logic [2:0] MD_OP_DIV   = 3'd2;
    localparam logic [2:0] MD_OP_DIVU  = 3'd3;
    localparam logic [2:0] MD_OP_MADD  = 3'd4;
    localparam logic [2:0] MD_OP_MADDU = 3'd5;
    localparam logic [2:0] MD_OP_MSUB  = 3'd6;
    localparam logic [2:0] MD_OP_MSUBU = 3'd7;

    localparam logic [1:0] MD_WR_HI = 2'b01;
    localparam logic [1:0] MD_WR_LO = 2'b10;

    typedef enum logic {
        MD_STATE_IDLE = 1'b0,
        MD_STATE_RUN  = 1'b1
    } md_state_e;

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the E stage and the multiply/divide unit.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       write;
    logic [WIDTH-1:0] wdata;
    logic             cancel;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;

    modport master (
        output start, op, a, b, write, wdata, cancel,
        input  hi, lo, busy
    );

    modport slave (
        input  start, op, a, b, write, wdata, cancel,
        output hi, lo, busy
    );
endinterface

// File: rtl/muldiv_divider.sv
// Combinational signed/unsigned divider producing quotient, remainder and a
// divide-by-zero flag; signed most-negative / -1 is pinned to a defined result.
module muldiv_divider #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic             neg_a;
    logic             neg_b;
    logic             overflow;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;

    // Divide magnitudes, then restore signs: quotient truncates toward zero,
    // remainder follows the dividend's sign.
    always_comb begin
        neg_a       = is_signed & dividend[WIDTH-1];
        neg_b       = is_signed & divisor[WIDTH-1];
        mag_a       = neg_a ? -dividend : dividend;
        mag_b       = neg_b ? -divisor : divisor;
        div_by_zero = (divisor == '0);
        overflow    = is_signed && (dividend == MOST_NEG) && (divisor == '1);
        q_mag       = '0;
        r_mag       = '0;
        if (!div_by_zero) begin
            q_mag = mag_a / mag_b;
            r_mag = mag_a % mag_b;
        end
        quotient  = (neg_a ^ neg_b) ? -q_mag : q_mag;
        remainder = neg_a ? -r_mag : r_mag;
        if (overflow) begin
            quotient  = MOST_NEG;
            remainder = '0;
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// E-stage multiply/divide unit: computes the full result at Start into a
// shadow pair and commits it to HI/LO after a fixed, op-dependent latency.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input logic           clk,
    input logic           reset,
    muldiv_unit_if.slave  bus
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    md_state_e          state;
    md_state_e          state_next;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   s_hi;
    logic [WIDTH-1:0]   s_lo;
    logic               launch;
    logic               commit;
    logic               wr_hi;
    logic               wr_lo;

    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic               div_zero;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic [2*WIDTH-1:0] result;

    muldiv_divider #(.WIDTH(WIDTH)) u_divider (
        .dividend    (bus.a),
        .divisor     (bus.b),
        .is_signed   (bus.op == MD_OP_DIV),
        .quotient    (quot),
        .remainder   (rem),
        .div_by_zero (div_zero)
    );

    // Products are formed at 2*WIDTH so accumulate wraps modulo 2^(2*WIDTH);
    // divide by zero reproduces the current HI/LO so completion is a no-op.
    always_comb begin
        acc    = {hi_q, lo_q};
        prod_s = {{WIDTH{bus.a[WIDTH-1]}}, bus.a} * {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
        prod_u = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
        result = acc;
        case (bus.op)
            MD_OP_MULT:              result = prod_s;
            MD_OP_MULTU:             result = prod_u;
            MD_OP_DIV, MD_OP_DIVU:   result = div_zero ? acc : {rem, quot};
            MD_OP_MADD:              result = acc + prod_s;
            MD_OP_MADDU:             result = acc + prod_u;
            MD_OP_MSUB:              result = acc - prod_s;
            MD_OP_MSUBU:             result = acc - prod_u;
            default:                 result = acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= MD_STATE_IDLE;
        else       state <= state_next;
    end

    // Cancel beats both a same-cycle Start and the completion edge.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        commit     = 1'b0;
        wr_hi      = 1'b0;
        wr_lo      = 1'b0;
        case (state)
            MD_STATE_IDLE: begin
                if (bus.start) begin
                    if (!bus.cancel) begin
                        launch     = 1'b1;
                        state_next = MD_STATE_RUN;
                    end
                end else begin
                    wr_hi = (bus.write == MD_WR_HI);
                    wr_lo = (bus.write == MD_WR_LO);
                end
            end
            MD_STATE_RUN: begin
                if (bus.cancel) begin
                    state_next = MD_STATE_IDLE;
                end else if (cnt == CNT_W'(1)) begin
                    commit     = 1'b1;
                    state_next = MD_STATE_IDLE;
                end
            end
            default: state_next = MD_STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
            s_hi <= '0;
            s_lo <= '0;
            cnt  <= '0;
        end else begin
            if (launch) begin
                {s_hi, s_lo} <= result;
                cnt          <= md_is_div(bus.op) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
            end else if (state == MD_STATE_RUN) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (commit) begin
                hi_q <= s_hi;
                lo_q <= s_lo;
            end
            if (wr_hi) hi_q <= bus.wdata;
            if (wr_lo) lo_q <= bus.wdata;
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state == MD_STATE_RUN);
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with hand-computed HI/LO results.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic clk = 1'b0;
    logic reset;
    int   vec_count  = 0;
    int   miss_count = 0;

    muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

    muldiv_unit #(
        .WIDTH   (WIDTH),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // The hazard unit must never let Start or a HI/LO write reach a busy unit.
    always @(posedge clk) begin
        if (!reset && bus.busy && (bus.start || bus.write == MD_WR_HI || bus.write == MD_WR_LO))
            $error("[TB] illegal start/write while busy");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vec_count++;
        if (observed !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkHiLo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        checkOutput({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
        checkOutput({tag, "_hilo"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
    endtask

    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int lat);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < lat; i++) begin
            checkOutput($sformatf("%s_busy_c%0d", tag, i + 1), {63'd0, bus.busy}, 64'd1);
            tick();
        end
    endtask

    task automatic writeReg(input logic [1:0] sel, input logic [31:0] data);
        bus.write = sel;
        bus.wdata = data;
        tick();
        bus.write = 2'b00;
    endtask

    initial begin
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.op     = MD_OP_MULT;
        bus.a      = '0;
        bus.b      = '0;
        bus.write  = 2'b00;
        bus.wdata  = '0;
        bus.cancel = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        checkHiLo("reset", 32'h0, 32'h0);

        applyStimulus("mult", MD_OP_MULT, 32'hFFFF_FFFF, 32'd2, MUL_LAT);
        checkHiLo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        applyStimulus("multu", MD_OP_MULTU, 32'hFFFF_FFFF, 32'd2, MUL_LAT);
        checkHiLo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

        applyStimulus("div", MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, DIV_LAT);
        checkHiLo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        applyStimulus("div_ovf", MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT);
        checkHiLo("div_ovf", 32'h0, 32'h8000_0000);

        writeReg(MD_WR_HI, 32'h1234_5678);
        checkHiLo("mthi", 32'h1234_5678, 32'h8000_0000);
        applyStimulus("divu0", MD_OP_DIVU, 32'd7, 32'd0, DIV_LAT);
        checkHiLo("divu0", 32'h1234_5678, 32'h8000_0000);

        writeReg(2'b11, 32'hDEAD_BEEF);
        checkHiLo("wr11", 32'h1234_5678, 32'h8000_0000);

        writeReg(MD_WR_LO, 32'hFFFF_FFFF);
        writeReg(MD_WR_HI, 32'h0);
        checkHiLo("mtlo_mthi", 32'h0, 32'hFFFF_FFFF);
        applyStimulus("maddu", MD_OP_MADDU, 32'd1, 32'd1, MUL_LAT);
        checkHiLo("maddu", 32'h1, 32'h0);
        applyStimulus("msub", MD_OP_MSUB, 32'd1, 32'd1, MUL_LAT);
        checkHiLo("msub", 32'h0, 32'hFFFF_FFFF);

        // Cancel in busy cycle 3, then confirm the discarded result never lands.
        bus.op = MD_OP_MULT; bus.a = 32'd3; bus.b = 32'd4; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        checkHiLo("cancel_run", 32'h0, 32'hFFFF_FFFF);
        repeat (MUL_LAT) tick();
        checkHiLo("cancel_late", 32'h0, 32'hFFFF_FFFF);

        bus.op = MD_OP_MULT; bus.a = 32'd5; bus.b = 32'd5;
        bus.start = 1'b1; bus.cancel = 1'b1;
        tick();
        bus.start = 1'b0; bus.cancel = 1'b0;
        for (int i = 0; i < MUL_LAT + 1; i++) begin
            checkOutput($sformatf("start_cancel_busy_c%0d", i + 1), {63'd0, bus.busy}, 64'd0);
            tick();
        end
        checkHiLo("start_cancel", 32'h0, 32'hFFFF_FFFF);

        // Cancel landing on the completion edge wins over the commit.
        bus.op = MD_OP_MULTU; bus.a = 32'd1; bus.b = 32'd1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (MUL_LAT - 1) tick();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        checkHiLo("cancel_last", 32'h0, 32'hFFFF_FFFF);

        bus.write = MD_WR_LO; bus.wdata = 32'hDEAD_BEEF;
        applyStimulus("start_write", MD_OP_MULT, 32'd2, 32'd3, 0);
        bus.write = 2'b00;
        checkOutput("start_write_lo_c1", {32'd0, bus.lo}, {32'd0, 32'hFFFF_FFFF});
        repeat (MUL_LAT) tick();
        checkHiLo("start_write", 32'h0, 32'h6);

        bus.op = MD_OP_MULT; bus.a = 32'd7; bus.b = 32'd7; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkHiLo("reset_mid", 32'h0, 32'h0);
        repeat (MUL_LAT) tick();
        checkHiLo("reset_late", 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised successor to the E-stage multiply/divide unit. It keeps the HI/LO register pair and a Busy handshake with programmable multiply and divide latencies. It adds multiply-accumulate modes (madd/maddu/msub/msubu) and a Cancel input so E-stage exceptions and flushes can abort an operation. It sits beside the ALU in the E stage; the hazard unit stalls D on (Start | Busy) whenever a HI/LO-reading or HI/LO-writing instruction is in D.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
MUL_LAT, 5, Busy cycles for mult/multu/madd/maddu/msub/msubu; must be >= 1.
DIV_LAT, 10, Busy cycles for div/divu; must be >= 1.

Ports:
Clk  in  1  clock, rising edge.
Reset  in  1  synchronous, active-high reset.
Start  in  1  one-cycle request; launches Op on A,B.
Op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 madd, 5 maddu, 6 msub, 7 msubu.
A  in  WIDTH  forwarded rs operand.
B  in  WIDTH  forwarded rt operand.
Write  in  2  01 mthi, 10 mtlo; 00 and 11 mean no write.
WData  in  WIDTH  data for mthi/mtlo (same as A).
Cancel  in  1  abort the in-flight operation or the same-cycle Start.
HI  out  WIDTH  architectural HI.
LO  out  WIDTH  architectural LO.
Busy  out  1  operation in progress.

Behaviour:
- Reset (checked at every edge, including mid-operation): HI=0, LO=0, Busy=0, counter=0, pending result discarded.
- States: IDLE and RUN. Busy=1 exactly when the state is RUN.
- IDLE + Start & !Cancel at edge N:
  - Latch the full 2*WIDTH result into the shadow pair {sHI,sLO}.
  - Load counter with MUL_LAT or DIV_LAT; go to RUN.
  - Busy is high for cycles N+1 .. N+LAT.
- RUN: counter decrements each edge.
  - At the edge where counter==1: HI<=sHI, LO<=sLO, go to IDLE.
  - New values are visible and Busy=0 in cycle N+LAT+1.
- Arithmetic:
  - mult/multu: {HI,LO} = A*B, signed or unsigned, 2*WIDTH bits.
  - madd(u): {HI,LO} + A*B; msub(u): {HI,LO} - A*B.
  - Accumulate uses HI/LO as they stand at the Start edge; results wrap modulo 2^(2*WIDTH).
  - div: LO = quotient truncated toward zero; HI = remainder, which carries the dividend's sign.
  - divu: unsigned quotient and remainder.
  - Signed overflow (most-negative / -1): LO = 0x80000000, HI = 0.
  - Divide by zero (div or divu): full latency still elapses; HI/LO unchanged at completion.
- Write (IDLE, no Start): mthi writes HI at the edge; mtlo writes LO at the edge. Busy stays 0.
- Simultaneous events:
  - Start & Write in the same cycle: Start wins, Write is ignored.
  - Start while RUN: ignored. Write while RUN: ignored. The stall logic must prevent both; the bench asserts on them.
  - Cancel in IDLE with Start: no launch and no HI/LO change.
  - Cancel in RUN: next edge goes to IDLE with Busy=0; HI/LO unchanged; the shadow result is discarded.
  - Cancel on the completion edge (counter==1): cancel wins and HI/LO are not updated.
- HI/LO are never visible mid-operation; there are no partial results.

Decomposition:
- Shared package holds:
  - MD_OP_* encodings for the 8 ops.
  - MD_WR_HI = 2'b01, MD_WR_LO = 2'b10.
  - MD_STATE_IDLE and MD_STATE_RUN.
- One sub-module: muldiv_divider. It is combinational and computes signed/unsigned quotient and remainder, including the divide-by-zero flag and overflow handling. The top level holds the FSM, counter, shadow registers and multiply/accumulate logic.

Test Plan:
- Reset, then mult with A=0xFFFFFFFF, B=2 (MUL_LAT=5) -> Busy high cycles 1-5; cycle 6: HI=0xFFFFFFFF, LO=0xFFFFFFFE, Busy=0.
- multu with A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 Busy cycles.
- div with A=-7 (0xFFFFFFF9), B=2 -> after 10 Busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div with A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi 0x12345678, then divu 7/0 -> HI=0x12345678 and LO unchanged after 10 Busy cycles.
- mtlo 0xFFFFFFFF, mthi 0, then maddu A=1, B=1 -> HI=1, LO=0. Then msub A=1, B=1 -> HI=0, LO=0xFFFFFFFF.
- mult started, Cancel asserted in Busy cycle 3 -> Busy=0 in the next cycle; HI/LO keep their pre-start values.
- Start+Cancel in the same cycle -> Busy never rises.
- Reset asserted in Busy cycle 2 -> HI=LO=0 and Busy=0 on the next cycle.
